synapse_row_fetcher: RTL
========================

# synapse_row_fetcher

Wishbone-master sequencer that drives the synapse matrix on behalf of the spike path. Incoming axon spikes (8-bit axon indices) are buffered in a small FIFO. Each spike is turned into a single-word read of its synapse row at BASE_ADDR + axon×4. The returned 32-bit connection word is presented to the neuron-update stage over a valid/ready handshake. It sits between the spike input and the synapse_matrix slave, in place of CPU-driven row reads.

## Interface
- BASE_ADDR, 32'h3000_0000, byte address of synapse row 0
- FIFO_DEPTH, 8, spike FIFO entries; power of two, ≥2
- TIMEOUT, 16, max cycles in REQ waiting for ack; ≥2

- wb_clk_i  in  1  clock, all state on rising edge
- wb_rst_i  in  1  reset, asynchronous, active-high
- enable_i  in  1  when low, no new FIFO pops; in-flight fetch completes
- spike_valid_i  in  1  spike offered
- spike_axon_i  in  8  axon index (row 0..255)
- spike_ready_o  out  1  = FIFO not full
- m_cyc_o  out  1  Wishbone cycle
- m_stb_o  out  1  Wishbone strobe, always equal to m_cyc_o
- m_we_o  out  1  constant 0
- m_sel_o  out  4  constant 4'hF
- m_adr_o  out  32  BASE_ADDR + {axon, 2'b00}
- m_ack_i  in  1  slave acknowledge
- syn_conn_i  in  32  synapse_matrix neurons_connections_o, valid when m_ack_i=1
- conn_valid_o  out  1  connection word available
- conn_ready_i  in  1  consumer accepts
- conn_data_o  out  32  captured connection word
- conn_axon_o  out  8  axon the word belongs to
- busy_o  out  1  state≠IDLE or FIFO non-empty
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  entries held
- err_timeout_o  out  1  one-cycle pulse on fetch abort

## Operation
- Spike FIFO: push on edge with spike_valid_i & spike_ready_o. Wrapping read/write pointers plus an occupancy count. No fall-through: an entry pushed at edge E cannot be popped before E+1.
- FSM states IDLE, REQ, OUT.
- IDLE: if enable_i & FIFO non-empty, pop at this edge and enter REQ. On the same edge, register m_cyc_o=m_stb_o=1, m_adr_o from the popped axon, conn_axon_o=axon, and clear the timeout counter.
- REQ: m_ack_i sampled high → capture syn_conn_i into conn_data_o, set conn_valid_o=1, deassert cyc/stb, enter OUT. Otherwise increment the counter.
- REQ timeout: reaching TIMEOUT edges without ack → deassert cyc/stb, pulse err_timeout_o, enter IDLE. The spike is discarded. Ack on the same edge as expiry wins and is treated as a normal ack.
- OUT: hold conn_valid_o/conn_data_o/conn_axon_o stable until conn_ready_i is sampled high. On acceptance, conn_valid_o←0. If enable_i & FIFO non-empty, pop and go directly to REQ (back-to-back); else go to IDLE.
- m_adr_o holds its value outside REQ; don't care to the slave.
- Exactly one outstanding Wishbone transaction; no bursts, no writes.
- enable_i deasserted in REQ/OUT: the current fetch runs to completion, then the FSM stays in IDLE.

## Timing
- Reset values: state IDLE, m_cyc_o=m_stb_o=0, m_adr_o=BASE_ADDR, conn_valid_o=0, conn_data_o=0, conn_axon_o=0, err_timeout_o=0, FIFO empty (spike_ready_o=1, fifo_level_o=0, busy_o=0).
- m_we_o=0 and m_sel_o=4'hF at all times, including during reset.
- Latency, spike push edge E with an empty, idle block:
  - pop/cyc at E+1
  - with single-cycle-ack slave (ack high the cycle after stb): ack sampled at E+2, conn_valid_o high after E+2
  - 2 cycles from push to valid word
- Steady-state throughput with conn_ready_i=1 and a single-cycle-ack slave: one word per 2 cycles (REQ, OUT alternate).
- FIFO full: spike_ready_o=0, and a push offered that cycle is not taken. A pop and a new push can occur on the same edge when not full; level is unchanged.
- Reset asserted mid-REQ: cyc/stb drop asynchronously, the FIFO is flushed, and no pulse is raised. A late ack after reset is ignored (state IDLE).

## Test plan
- Single spike, axon 8'h05, slave returns 32'hDEAD_BEEF with 1-cycle ack → m_adr_o=32'h3000_0014 with cyc/stb for exactly one ack, conn_valid_o with conn_data_o=32'hDEAD_BEEF, conn_axon_o=8'h05, 2 cycles after push.
- Write all 256 rows with random data via the CPU port, then stream axons 0..255 with conn_ready_i=1 → 256 words in order, each equal to the written row, no errors.
- Push 9 spikes with conn_ready_i=0, FIFO_DEPTH=8 → one popped into REQ/OUT, 8 in FIFO, spike_ready_o=0, fifo_level_o=8. Release conn_ready_i → all 9 words delivered in push order.
- Slave never acks (TIMEOUT=16) → cyc/stb high exactly 16 cycles, err_timeout_o one-cycle pulse, next spike fetched normally.
- Assert wb_rst_i during REQ with 3 spikes queued → cyc/stb/conn_valid_o 0 immediately, fifo_level_o=0. After release, a new spike fetches correctly.
- enable_i=0 with 4 spikes queued → no cyc for 20 cycles. enable_i=1 → 4 fetches in order.

Source files
------------

// File: rtl/synapse_row_fetcher_if.sv
// Wishbone read channel between the synapse row fetcher (master) and the
// synapse matrix (slave). The master only ever issues single-word reads.
interface synapse_row_fetcher_if;
  logic        m_cyc_o;
  logic        m_stb_o;
  logic        m_we_o;
  logic [3:0]  m_sel_o;
  logic [31:0] m_adr_o;
  logic        m_ack_i;
  logic [31:0] syn_conn_i;

  modport master (
    output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o,
    input  m_ack_i, syn_conn_i
  );

  modport slave (
    input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o,
    output m_ack_i, syn_conn_i
  );
endinterface

// File: rtl/synapse_row_fetcher.sv
// Synapse row fetcher: buffers incoming axon spikes, turns each one into a
// single Wishbone read of its synapse row and hands the returned connection
// word to the neuron-update stage over a valid/ready handshake.
module synapse_row_fetcher #(
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 8,
  parameter int          TIMEOUT    = 16
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          enable_i,
  input  logic                          spike_valid_i,
  input  logic [7:0]                    spike_axon_i,
  output logic                          spike_ready_o,
  synapse_row_fetcher_if.master         wb,
  output logic                          conn_valid_o,
  input  logic                          conn_ready_i,
  output logic [31:0]                   conn_data_o,
  output logic [7:0]                    conn_axon_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic                          err_timeout_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int TMO_W = $clog2(TIMEOUT);
  localparam logic [PTR_W:0] LVL_FULL = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_OUT
  } state_t;

  // Spike FIFO storage and bookkeeping
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  // Sequencer state and registered outputs
  state_t           r_state;
  logic             r_cyc;
  logic [31:0]      r_adr;
  logic             r_valid;
  logic [31:0]      r_data;
  logic [7:0]       r_axon;
  logic             r_err;
  logic [TMO_W-1:0] r_tmo;

  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_head;

  assign w_full  = (r_count == LVL_FULL);
  assign w_empty = (r_count == '0);
  assign w_push  = spike_valid_i & ~w_full;
  assign w_head  = r_mem[r_rd_ptr];

  // A pop happens only when the sequencer is free to start a new fetch:
  // from IDLE, or from OUT on the edge the current word is accepted.
  assign w_pop = enable_i & ~w_empty &
                 ((r_state == S_IDLE) | ((r_state == S_OUT) & conn_ready_i));

  // FIFO payload write; no fall-through, the head is always a registered entry
  // NOTE: storage arrays are left out of reset; the occupancy count already
  // marks every entry invalid, and resetting the array would cost a reset
  // tree on every bit for no functional gain.
  always_ff @(posedge wb_clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= spike_axon_i;
  end

  // FIFO pointers and occupancy count; pointers wrap naturally (power of two)
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge values of its inputs regardless of statement order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Fetch sequencer: IDLE -> REQ (one Wishbone read) -> OUT (hand-off)
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state <= S_IDLE;
      r_cyc   <= 1'b0;
      r_adr   <= BASE_ADDR;
      r_valid <= 1'b0;
      r_data  <= '0;
      r_axon  <= '0;
      r_err   <= 1'b0;
      r_tmo   <= '0;
    end else begin
      r_err <= 1'b0;

      unique case (r_state)
        S_IDLE: ;
        S_REQ: begin
          // An ack on the expiry edge is checked first, so it wins.
          if (wb.m_ack_i) begin
            r_data  <= wb.syn_conn_i;
            r_valid <= 1'b1;
            r_cyc   <= 1'b0;
            r_state <= S_OUT;
          end else if (r_tmo == TMO_LAST) begin
            r_cyc   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        S_OUT: begin
          if (conn_ready_i) begin
            r_valid <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase

      // Starting a fetch overrides the IDLE fallback above, which gives the
      // back-to-back OUT -> REQ transition without a bubble.
      if (w_pop) begin
        r_state <= S_REQ;
        r_cyc   <= 1'b1;
        r_adr   <= BASE_ADDR + {22'd0, w_head, 2'b00};
        r_axon  <= w_head;
        r_tmo   <= '0;
      end
    end
  end

  assign wb.m_cyc_o = r_cyc;
  assign wb.m_stb_o = r_cyc;
  assign wb.m_we_o  = 1'b0;
  assign wb.m_sel_o = 4'hF;
  assign wb.m_adr_o = r_adr;

  assign spike_ready_o = ~w_full;
  assign conn_valid_o  = r_valid;
  assign conn_data_o   = r_data;
  assign conn_axon_o   = r_axon;
  assign err_timeout_o = r_err;
  assign fifo_level_o  = r_count;
  assign busy_o        = (r_state != S_IDLE) | ~w_empty;

endmodule
